// File: rtl/reset_sequencer.sv
// Staged reset sequencer: qualifies a synchronised PLL lock, then releases
// NUM_CH active-low resets one at a time and re-arms on lock loss or soft request.
module reset_sequencer #(
  parameter int NUM_CH       = 4,
  parameter int LOCK_STABLE  = 64,
  parameter int STAGE_DELAY  = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              soft_rst_req,
  input  logic              err_clr,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              done,
  output logic              error,
  output logic              lost_flag,
  output logic              timeout_flag,
  output logic [CNT_W-1:0]  loss_cnt,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int CNT_MAX = (LOCK_STABLE > STAGE_DELAY) ? LOCK_STABLE : STAGE_DELAY;
  localparam int SCW     = $clog2(CNT_MAX + 1);
  localparam int STW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW      = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  localparam logic [SCW-1:0] LOCK_LAST  = SCW'(LOCK_STABLE - 1);
  localparam logic [SCW-1:0] STAGE_LAST = SCW'(STAGE_DELAY - 1);
  localparam logic [STW-1:0] LAST_CH    = STW'(NUM_CH - 1);
  localparam logic [TW-1:0]  T_LAST     = TW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  // tcnt parks one past the flag point so the timeout can fire only once per arm.
  localparam logic [TW-1:0]  T_SAT      = TW'(LOCK_TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_t             state, state_d;
  logic [SCW-1:0]     stab_cnt, stab_d;
  logic [STW-1:0]     stage, stage_d;
  logic [TW-1:0]      tcnt, tcnt_d;
  logic [NUM_CH-1:0]  rst_n_d;
  logic               done_d, lost_d, timeout_d;
  logic [CNT_W-1:0]   loss_d;
  logic               loss_set, timeout_set;

  assign lock_s  = sync_q[SYNC_STAGES-1];
  assign error   = lost_flag | timeout_flag;
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  always_comb begin
    // NOTE: every output of this block is given a default first so no path can infer a latch.
    state_d     = state;
    stab_d      = stab_cnt;
    stage_d     = stage;
    tcnt_d      = tcnt;
    rst_n_d     = rst_n_out;
    done_d      = done;
    loss_set    = 1'b0;
    timeout_set = 1'b0;

    case (state)
      WAIT_LOCK: begin
        if (tcnt != T_SAT) tcnt_d = tcnt + 1'b1;
        if (LOCK_TIMEOUT != 0 && tcnt == T_LAST) timeout_set = 1'b1;
        if (lock_s) begin
          if (stab_cnt == LOCK_LAST) begin
            state_d = RELEASE;
            stab_d  = '0;
            stage_d = '0;
            tcnt_d  = '0;
          end else begin
            stab_d = stab_cnt + 1'b1;
          end
        end else begin
          stab_d = '0;
        end
      end

      RELEASE, RUN: begin
        // Lock loss takes precedence over a soft request so a coincident pair counts once.
        if (!lock_s || soft_rst_req) begin
          state_d  = WAIT_LOCK;
          rst_n_d  = '0;
          done_d   = 1'b0;
          stab_d   = '0;
          stage_d  = '0;
          tcnt_d   = '0;
          loss_set = !lock_s;
        end else if (state == RELEASE) begin
          if (stab_cnt == STAGE_LAST) begin
            rst_n_d[stage] = 1'b1;
            stab_d         = '0;
            if (stage == LAST_CH) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              stage_d = stage + 1'b1;
            end
          end else begin
            stab_d = stab_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        rst_n_d = '0;
        done_d  = 1'b0;
        stab_d  = '0;
        stage_d = '0;
        tcnt_d  = '0;
      end
    endcase

    // Set beats clear when both happen in the same cycle.
    lost_d    = loss_set    | (lost_flag    & ~err_clr);
    timeout_d = timeout_set | (timeout_flag & ~err_clr);
    loss_d    = (loss_set && loss_cnt != '1) ? loss_cnt + 1'b1 : loss_cnt;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
    if (rst) begin
      state        <= WAIT_LOCK;
      stab_cnt     <= '0;
      stage        <= '0;
      tcnt         <= '0;
      rst_n_out    <= '0;
      done         <= 1'b0;
      lost_flag    <= 1'b0;
      timeout_flag <= 1'b0;
      loss_cnt     <= '0;
    end else begin
      state        <= state_d;
      stab_cnt     <= stab_d;
      stage        <= stage_d;
      tcnt         <= tcnt_d;
      rst_n_out    <= rst_n_d;
      done         <= done_d;
      lost_flag    <= lost_d;
      timeout_flag <= timeout_d;
      loss_cnt     <= loss_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected channel/state snapshots are queued
// against absolute edge numbers and compared as the clock reaches them.
module tb_reset_sequencer;

  logic       clk;
  logic       rst, pll_locked, soft_rst_req, err_clr;
  logic [3:0] rst_n_out;
  logic       done, error, lost_flag, timeout_flag;
  logic [7:0] loss_cnt;
  logic [1:0] state_o;

  logic       rst2, pll2;
  logic [1:0] rst_n_out2;
  logic       done2, error2, lost2, timeout2;
  logic [1:0] loss_cnt2;
  logic [1:0] state2;

  reset_sequencer dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .err_clr(err_clr), .rst_n_out(rst_n_out), .done(done), .error(error),
    .lost_flag(lost_flag), .timeout_flag(timeout_flag), .loss_cnt(loss_cnt),
    .state_o(state_o)
  );

  reset_sequencer #(
    .NUM_CH(2), .LOCK_STABLE(4), .STAGE_DELAY(2), .SYNC_STAGES(2),
    .LOCK_TIMEOUT(0), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst2), .pll_locked(pll2), .soft_rst_req(1'b0),
    .err_clr(1'b0), .rst_n_out(rst_n_out2), .done(done2), .error(error2),
    .lost_flag(lost2), .timeout_flag(timeout2), .loss_cnt(loss_cnt2),
    .state_o(state2)
  );

  typedef struct {
    int         at;
    string      tag;
    logic [3:0] rst_n;
    logic       done;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   t0, t1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int at, input string tag, input logic [3:0] rn,
                      input logic d, input logic [1:0] st);
    exp_t e;
    e.at = at; e.tag = tag; e.rst_n = rn; e.done = d; e.st = st;
    sb.push_back(e);
  endtask

  // One rising edge, then sample on the falling edge and retire due entries.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) check({e.tag, "_missed"}, cyc, e.at);
      else check(e.tag, {rst_n_out, done, state_o}, {e.rst_n, e.done, e.st});
    end
  endtask

  task automatic run_sb(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("sb_budget", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic push_release(input int base, input string pfx);
    push(base + 81,  {pfx, "_pre0"}, 4'b0000, 1'b0, 2'd1);
    push(base + 82,  {pfx, "_ch0"},  4'b0001, 1'b0, 2'd1);
    push(base + 98,  {pfx, "_ch1"},  4'b0011, 1'b0, 2'd1);
    push(base + 114, {pfx, "_ch2"},  4'b0111, 1'b0, 2'd1);
    push(base + 129, {pfx, "_pre3"}, 4'b0111, 1'b0, 2'd1);
    push(base + 130, {pfx, "_ch3"},  4'b1111, 1'b1, 2'd2);
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b0; soft_rst_req = 1'b0; err_clr = 1'b0;
    rst2 = 1'b1; pll2 = 1'b0;

    // Reset values and the default release schedule.
    repeat (3) tick();
    check("rst_outs", {rst_n_out, done, state_o}, {4'b0000, 1'b0, 2'd0});
    check("rst_flags", {error, lost_flag, timeout_flag, loss_cnt}, 0);
    rst = 1'b0; pll_locked = 1'b1; t0 = cyc;
    push(t0 + 65, "s1_wait", 4'b0000, 1'b0, 2'd0);
    push(t0 + 66, "s1_rel",  4'b0000, 1'b0, 2'd1);
    push_release(t0, "s1");
    run_sb(200);
    check("s1_error", error, 1'b0);

    // Lock chatter shorter than the stability window never releases.
    rst = 1'b1; pll_locked = 1'b0;
    repeat (2) tick();
    rst = 1'b0; t0 = cyc;
    for (int k = 1; k <= 4; k++) push(t0 + 100 * k, "s2_glitch", 4'b0000, 1'b0, 2'd0);
    for (int i = 0; i < 495; i++) begin
      pll_locked = (i % 11) != 10;
      tick();
    end
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1; t0 = cyc;
    push_release(t0, "s2");
    run_sb(200);

    // One-cycle lock drop in RUN: abort on one edge, then a full re-sequence.
    pll_locked = 1'b0; t0 = cyc;
    push(t0 + 2,   "s3_hold",  4'b1111, 1'b1, 2'd2);
    push(t0 + 3,   "s3_abort", 4'b0000, 1'b0, 2'd0);
    push(t0 + 130, "s3_pre3",  4'b0111, 1'b0, 2'd1);
    push(t0 + 131, "s3_done",  4'b1111, 1'b1, 2'd2);
    tick();
    pll_locked = 1'b1;
    run_sb(200);
    check("s3_lost", {lost_flag, error, timeout_flag}, 3'b110);
    check("s3_cnt", loss_cnt, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("s3_clr", {lost_flag, error}, 2'b00);
    check("s3_cnt_kept", loss_cnt, 1);

    // Soft requests re-arm without touching the loss bookkeeping.
    soft_rst_req = 1'b1; t0 = cyc;
    push(t0 + 1,  "s4_soft_run", 4'b0000, 1'b0, 2'd0);
    push(t0 + 97, "s4_ch1",      4'b0011, 1'b0, 2'd1);
    tick();
    soft_rst_req = 1'b0;
    run_sb(200);
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0; t1 = cyc;
    check("s4_soft_rel", {rst_n_out, done, state_o}, {4'b0000, 1'b0, 2'd0});
    check("s4_soft_cnt", {lost_flag, loss_cnt}, {1'b0, 8'd1});
    push(t1 + 128, "s4_rerun", 4'b1111, 1'b1, 2'd2);
    run_sb(200);
    pll_locked = 1'b0;
    repeat (2) tick();
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0; pll_locked = 1'b1;
    check("s4_both", {rst_n_out, done, state_o}, {4'b0000, 1'b0, 2'd0});
    check("s4_both_cnt", {lost_flag, loss_cnt}, {1'b1, 8'd2});

    // Lock timeout: single shot per arm, err_clr clears, set wins over clear.
    rst = 1'b1; pll_locked = 1'b0;
    repeat (2) tick();
    rst = 1'b0; t0 = cyc;
    while (cyc < t0 + 4095) tick();
    check("s5_pre_to", timeout_flag, 1'b0);
    tick();
    check("s5_to", {timeout_flag, error, loss_cnt}, {1'b1, 1'b1, 8'd0});
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("s5_clr", {timeout_flag, error}, 2'b00);
    repeat (200) tick();
    check("s5_no_repeat", timeout_flag, 1'b0);
    pll_locked = 1'b1; t0 = cyc;
    push(t0 + 66, "s5_rel", 4'b0000, 1'b0, 2'd1);
    run_sb(100);
    pll_locked = 1'b0; t1 = cyc;
    repeat (3) tick();
    check("s5_abort", {state_o, lost_flag, loss_cnt}, {2'd0, 1'b1, 8'd1});
    while (cyc < t1 + 3 + 4095) tick();
    check("s5_pre_to2", timeout_flag, 1'b0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("s5_set_wins", {timeout_flag, lost_flag}, 2'b10);
    tick();
    check("s5_sticky", timeout_flag, 1'b1);

    // Narrow instance: loss_cnt saturation and reset mid-release.
    tick();
    rst2 = 1'b0; pll2 = 1'b1;
    repeat (20) tick();
    check("d2_run", {rst_n_out2, done2, state2}, {2'b11, 1'b1, 2'd2});
    for (int i = 0; i < 5; i++) begin
      pll2 = 1'b0; tick(); pll2 = 1'b1;
      repeat (2) tick();
      check($sformatf("d2_loss%0d", i), {state2, loss_cnt2},
            {2'd0, (i < 2) ? 2'(i + 1) : 2'd3});
      if (i < 4) begin
        repeat (20) tick();
        check($sformatf("d2_rerun%0d", i), state2, 2'd2);
      end
    end
    repeat (7) tick();
    check("d2_mid_rel", {rst_n_out2, done2, state2}, {2'b01, 1'b0, 2'd1});
    check("d2_no_to", timeout2, 1'b0);
    rst2 = 1'b1; tick();
    check("d2_rst", {rst_n_out2, done2, state2, lost2, error2, loss_cnt2},
          {2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-counter power-on reset: one sequencer per clock domain, driven from the free-running on-chip oscillator.
- Qualifies PLL lock over a stability window, then releases NUM_CH reset channels in stages, one every STAGE_DELAY cycles.
- Re-arms automatically when lock is lost or software requests a reset.
- Reports lock timeout, lock loss and a saturating loss count for the error/LED path.

Parameters:
NUM_CH, 4, number of staged reset outputs; minimum 1.
LOCK_STABLE, 64, consecutive synchronised-lock cycles required before release; minimum 1.
STAGE_DELAY, 16, cycles between successive channel releases; minimum 1.
SYNC_STAGES, 2, synchroniser depth for pll_locked; minimum 2.
LOCK_TIMEOUT, 4096, WAIT_LOCK cycles before timeout error is flagged; 0 disables the timeout.
CNT_W, 8, width of loss_cnt.

Ports:
clk  in  1  oscillator clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
pll_locked  in  1  asynchronous PLL lock indication.
soft_rst_req  in  1  software re-sequence request; level-sensitive, sampled each cycle.
err_clr  in  1  clears the sticky error flags.
rst_n_out  out  NUM_CH  active-low channel resets; bit k releases k-th.
done  out  1  high when all channels are released.
error  out  1  timeout_flag OR lost_flag.
lost_flag  out  1  sticky: lock lost during RELEASE or RUN.
timeout_flag  out  1  sticky: LOCK_TIMEOUT cycles elapsed in WAIT_LOCK.
loss_cnt  out  CNT_W  saturating count of lock-loss events.
state_o  out  2  current state: 0=WAIT_LOCK, 1=RELEASE, 2=RUN.

Behaviour:
- Reset (rst=1, highest priority): state=WAIT_LOCK; rst_n_out=0; done=0; flags=0; loss_cnt=0; synchroniser, stab_cnt, stage, tcnt all 0.
- pll_locked passes through SYNC_STAGES flops (reset 0) to give lock_s. All decisions use lock_s.
- WAIT_LOCK:
  - lock_s=1: stab_cnt++. lock_s=0: stab_cnt=0.
  - When lock_s=1 and stab_cnt==LOCK_STABLE-1: go to RELEASE; stab_cnt=0; stage=0; tcnt=0.
  - tcnt increments every cycle in WAIT_LOCK and saturates. When tcnt reaches LOCK_TIMEOUT-1 (LOCK_TIMEOUT≠0), set timeout_flag. Waiting continues; the flag does not block release.
  - soft_rst_req is ignored in this state.
- RELEASE:
  - stab_cnt counts 0..STAGE_DELAY-1. On the terminal count: rst_n_out[stage]<=1; stage++; stab_cnt=0.
  - On the edge that releases bit NUM_CH-1: go to RUN and set done<=1 on that same edge.
- RUN: holds all outputs; done=1.
- Abort from RELEASE or RUN:
  - lock_s=0 → same edge: rst_n_out<=0 (all), done<=0, lost_flag<=1, loss_cnt saturating increment (holds at all-ones), state=WAIT_LOCK, counters cleared.
  - soft_rst_req=1 (lock_s=1) → same actions except lost_flag and loss_cnt are unchanged.
  - Both in the same cycle → treated as lock loss; counted once.
- Release is monotonic: no channel is released before a lower-index channel. All channels re-assert together.
- Latency from a clean pll_locked rise (held high) to rst_n_out[k] rising: SYNC_STAGES + LOCK_STABLE + (k+1)*STAGE_DELAY cycles. done rises on the same edge as bit NUM_CH-1.
- err_clr=1 clears lost_flag and timeout_flag. If a set condition occurs in the same cycle, set wins. loss_cnt is cleared only by rst.
- Glitches on lock_s shorter than LOCK_STABLE in WAIT_LOCK restart stab_cnt and never release any channel.

Test Plan:
- Defaults, rst then pll_locked=1 held → rst_n_out[0] rises at cycle 82, [1] at 98, [2] at 114, [3] and done at 130; state_o=2; error=0.
- Lock pulses of 10 high / 1 low for 500 cycles → rst_n_out stays 0, state_o=0; later steady lock → normal release timing.
- In RUN, drop pll_locked for 1 cycle → after 2-cycle sync all rst_n_out=0 on one edge, lost_flag=1, loss_cnt=1, re-sequence completes 128 cycles after lock_s returns.
- soft_rst_req in RELEASE after stage 1 → all outputs 0, loss_cnt unchanged; same cycle as lock_s fall → loss_cnt increments by exactly 1.
- pll_locked=0 for 4096 cycles → timeout_flag=1, error=1; err_clr pulse with lock still absent → cleared, then re-set only on a new timeout after the next re-arm (tcnt saturates, no repeat).
- CNT_W=2, 5 lock losses → loss_cnt=3 (saturated); rst asserted mid-RELEASE → all outputs return to reset values on the next edge.
